// File: rtl/flush_word_unpacker_if.sv
// Handshake bundle between the flushing FIFO's read side, the nibble unpacker and its consumer.
interface flush_word_unpacker_if #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4
);
  logic              word_valid_i;
  logic [WORD_W-1:0] word_data_i;
  logic [3:0]        word_count_i;
  logic              word_ready_o;
  logic              nib_valid_o;
  logic [NIB_W-1:0]  nib_data_o;
  logic              nib_last_o;
  logic              nib_ready_i;
  logic              drop_o;
  logic [7:0]        drop_cnt_o;
  logic              busy_o;

  modport slave (
    input  word_valid_i, word_data_i, word_count_i, nib_ready_i,
    output word_ready_o, nib_valid_o, nib_data_o, nib_last_o, drop_o, drop_cnt_o, busy_o
  );

  modport master (
    output word_valid_i, word_data_i, word_count_i, nib_ready_i,
    input  word_ready_o, nib_valid_o, nib_data_o, nib_last_o, drop_o, drop_cnt_o, busy_o
  );
endinterface

// File: rtl/flush_word_unpacker.sv
// Buffers flushed FIFO words (up to DEPTH) and replays them as oldest-first nibbles;
// words arriving while the buffer is full are dropped and counted.
module flush_word_unpacker #(
  parameter int WORD_W = 32,
  parameter int NIB_W  = 4,
  parameter int DEPTH  = 2
) (
  input  logic                    rclock,
  input  logic                    reset,
  flush_word_unpacker_if.slave    bus
);
  localparam int          NIBS   = WORD_W / NIB_W;
  localparam int          PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          OW     = $clog2(DEPTH) + 1;
  localparam logic [3:0]  NIBS_C = 4'(NIBS);
  localparam logic [OW-1:0] FULL = OW'(DEPTH);
  localparam logic [0:0]  IDLE   = 1'b0;
  localparam logic [0:0]  SEND   = 1'b1;

  logic [WORD_W-1:0] mem_data [DEPTH];
  logic [3:0]        mem_cnt  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [OW-1:0]     occ;
  logic [0:0]        state;
  logic [WORD_W-1:0] shift_reg;
  logic [3:0]        remaining;
  logic              drop_q;
  logic [7:0]        drop_cnt;

  logic [3:0] count_clamp;
  logic       non_empty;
  logic       accept;
  logic       wr_en;
  logic       drop_en;
  logic       last_hs;
  logic       pop;

  // Fullness is judged on registered occupancy only, so a same-edge pop never makes room.
  always_comb begin
    count_clamp = (bus.word_count_i > NIBS_C) ? NIBS_C : bus.word_count_i;
    non_empty   = (occ != '0);
    accept      = bus.word_valid_i && (bus.word_count_i != 4'd0);
    wr_en       = accept && (occ < FULL);
    drop_en     = accept && (occ == FULL);
    last_hs     = (state == SEND) && bus.nib_ready_i && (remaining == 4'd1);
    pop         = non_empty && ((state == IDLE) || last_hs);
  end

  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
      drop_q   <= 1'b0;
      drop_cnt <= 8'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_cnt[i]  <= '0;
      end
    end else begin
      drop_q <= drop_en;
      if (drop_en && (drop_cnt != 8'hFF))
        drop_cnt <= drop_cnt + 8'd1;
      if (wr_en) begin
        mem_data[wr_ptr] <= bus.word_data_i;
        mem_cnt[wr_ptr]  <= count_clamp;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // A last-nibble handshake reloads from the buffer on the same edge, so words stream without a bubble.
  always_ff @(posedge rclock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      remaining <= '0;
    end else if (state == IDLE) begin
      if (pop) begin
        shift_reg <= mem_data[rd_ptr];
        remaining <= mem_cnt[rd_ptr];
        state     <= SEND;
      end
    end else if (bus.nib_ready_i) begin
      if (last_hs && non_empty) begin
        shift_reg <= mem_data[rd_ptr];
        remaining <= mem_cnt[rd_ptr];
      end else begin
        shift_reg <= shift_reg >> NIB_W;
        remaining <= remaining - 4'd1;
        if (last_hs)
          state <= IDLE;
      end
    end
  end

  assign bus.word_ready_o = (occ < FULL);
  assign bus.nib_valid_o  = (state == SEND);
  assign bus.nib_data_o   = shift_reg[NIB_W-1:0];
  assign bus.nib_last_o   = (state == SEND) && (remaining == 4'd1);
  assign bus.drop_o       = drop_q;
  assign bus.drop_cnt_o   = drop_cnt;
  assign bus.busy_o       = non_empty || (state == SEND);
endmodule
